// File: rtl/cavlc_stream_packer.sv
// MSB-first bit packer for concatenated CAVLC block codes, emitting OUT_W-bit words through a small FIFO.
// Optional macro CAVLC_PACK_RBSP_TRAIL_EN: flush inserts the rbsp_stop_one_bit before zero padding.
module cavlc_stream_packer #(
    parameter int CODE_W     = 128,
    parameter int LEN_W      = 8,
    parameter int OUT_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_word,
    output logic              out_last
);
    localparam int ACC_W  = OUT_W + CODE_W;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, FLUSH, PAD} state_t;

    state_t             state_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [FILL_W-1:0]  fill_reg;
    logic               pending_reg;
    logic               flush_done_reg;

    logic [OUT_W-1:0]   fifo_word [FIFO_DEPTH];
    logic               fifo_last [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_reg;
    logic [PTR_W:0]     rd_ptr_reg;

    logic [LEN_W-1:0]   len_c;
    logic [FILL_W-1:0]  len_f;
    logic [FILL_W-1:0]  shift_amt;
    logic [ACC_W-1:0]   len_mask;
    logic [ACC_W-1:0]   ins_bits;
    logic [ACC_W-1:0]   acc_after_in;
    logic [FILL_W-1:0]  fill_after_in;
    logic [FILL_W-1:0]  fill_minus;
    logic               hs;
    logic               pop;
    logic               fifo_full;
    logic               can_push;
    logic               push;
    logic [OUT_W-1:0]   push_word;
    logic               push_last;
    logic [OUT_W-1:0]   stop_bit;

    assign len_c = (in_len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : in_len;
    assign len_f = FILL_W'(len_c);

    // Keep only the in_len least-significant code bits; upper code bits are don't-care.
    for (genvar gi = 0; gi < ACC_W; gi++) begin : g_mask
        assign len_mask[gi] = (int'(len_c) > gi);
    end

    assign in_ready      = !rst && (state_reg == RUN) && (fill_reg < FILL_W'(OUT_W)) && !pending_reg;
    assign hs            = in_valid && in_ready;
    assign shift_amt     = FILL_W'(ACC_W) - fill_reg - len_f;
    assign ins_bits      = ({{OUT_W{1'b0}}, in_code} & len_mask) << shift_amt;
    assign acc_after_in  = hs ? (acc_reg | ins_bits) : acc_reg;
    assign fill_after_in = hs ? (fill_reg + len_f) : fill_reg;
    assign fill_minus    = fill_reg - FILL_W'(OUT_W);

    assign out_valid  = (wr_ptr_reg != rd_ptr_reg);
    assign out_word   = fifo_word[rd_ptr_reg[PTR_W-1:0]];
    assign out_last   = out_valid && fifo_last[rd_ptr_reg[PTR_W-1:0]];
    assign flush_done = flush_done_reg;
    assign pop        = out_valid && out_ready;
    assign fifo_full  = ((wr_ptr_reg - rd_ptr_reg) == (PTR_W+1)'(FIFO_DEPTH));
    assign can_push   = !fifo_full || pop;

`ifdef CAVLC_PACK_RBSP_TRAIL_EN
    assign stop_bit = {1'b1, {(OUT_W-1){1'b0}}} >> fill_reg;
`else
    assign stop_bit = '0;
`endif

    always_comb begin
        push      = 1'b0;
        push_word = acc_reg[ACC_W-1 -: OUT_W];
        push_last = 1'b0;
        if (state_reg == DRAIN) begin
            push = can_push;
        end else if (state_reg == PAD) begin
            push      = can_push;
            push_word = acc_reg[ACC_W-1 -: OUT_W] | stop_bit;
            push_last = 1'b1;
        end
    end

    // FIFO storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[wr_ptr_reg[PTR_W-1:0]] <= push_word;
            fifo_last[wr_ptr_reg[PTR_W-1:0]] <= push_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= RUN;
            acc_reg        <= '0;
            fill_reg       <= '0;
            pending_reg    <= 1'b0;
            flush_done_reg <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
        end else begin
            flush_done_reg <= 1'b0;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case (state_reg)
                RUN: begin
                    acc_reg  <= acc_after_in;
                    fill_reg <= fill_after_in;
                    if (flush_req) pending_reg <= 1'b1;
                    if (fill_after_in >= FILL_W'(OUT_W))
                        state_reg <= DRAIN;
                    else if (pending_reg || flush_req)
                        state_reg <= FLUSH;
                end
                DRAIN: begin
                    if (flush_req) pending_reg <= 1'b1;
                    if (push) begin
                        acc_reg  <= acc_reg << OUT_W;
                        fill_reg <= fill_minus;
                        if (fill_minus < FILL_W'(OUT_W))
                            state_reg <= (pending_reg || flush_req) ? FLUSH : RUN;
                    end
                end
                FLUSH: begin
`ifdef CAVLC_PACK_RBSP_TRAIL_EN
                    state_reg <= PAD;
`else
                    // An empty accumulator closes without emitting a word.
                    if (fill_reg != '0) begin
                        state_reg <= PAD;
                    end else begin
                        flush_done_reg <= 1'b1;
                        pending_reg    <= 1'b0;
                        state_reg      <= RUN;
                    end
`endif
                end
                PAD: begin
                    if (push) begin
                        acc_reg        <= '0;
                        fill_reg       <= '0;
                        flush_done_reg <= 1'b1;
                        pending_reg    <= 1'b0;
                        state_reg      <= RUN;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end
endmodule
